// File: rtl/regfile_wr_arbiter_if.sv
// ============================================================================
// regfile_wr_arbiter_if
// Bundle of the request/grant side and the register-file write side of the
// four-requester write arbiter.
//
//   req       [3:0]          per-requester write request (bit i = requester i)
//   req_addr  [11:0]         destination register, 3 bits per requester
//   req_data  [4*DATA_W-1:0] write data, DATA_W bits per requester
//   hold                     register-file stall, blocks all grants
//   gnt       [3:0]          one-hot grant (combinational)
//   wr_en                    registered write strobe
//   wr_sel    [2:0]          registered destination register index
//   wr_data   [DATA_W-1:0]   registered write data
//   busy                     registered: requests were pending but unserved
//
// master: requesters / stall source side. slave: the arbiter.
// ============================================================================
interface regfile_wr_arbiter_if #(
    parameter int DATA_W = 16
);
    logic [3:0]          req;
    logic [11:0]         req_addr;
    logic [4*DATA_W-1:0] req_data;
    logic                hold;
    logic [3:0]          gnt;
    logic                wr_en;
    logic [2:0]          wr_sel;
    logic [DATA_W-1:0]   wr_data;
    logic                busy;

    modport master (
        output req, req_addr, req_data, hold,
        input  gnt, wr_en, wr_sel, wr_data, busy
    );

    modport slave (
        input  req, req_addr, req_data, hold,
        output gnt, wr_en, wr_sel, wr_data, busy
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
// regfile_wr_arbiter
// Round-robin arbiter merging four register-file write requesters onto a
// single write port. Grant is combinational; the selected write is issued
// to the register file one cycle after the transfer edge.
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    regfile_wr_arbiter_if.slave (req/req_addr/req_data/hold in,
//          gnt/wr_en/wr_sel/wr_data/busy out)
//
// Optional feature macro: RF_WR_ZERO_DISCARD_EN
//   When defined, a transfer addressed to register 0 is granted and advances
//   the round-robin pointer but produces no write strobe (register 0 is
//   hard-wired to zero). When undefined, register 0 is written like any other.
// ============================================================================
module regfile_wr_arbiter #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wr_arbiter_if.slave   bus
);

    logic [1:0]        r_rr_ptr;

    logic [3:0]        w_gnt_p0;
    logic [1:0]        w_gnt_idx_p0;
    logic              w_xfer_p0;
    logic              w_wr_vld_p0;
    logic [2:0]        w_sel_p0;
    logic [DATA_W-1:0] w_data_p0;

    logic              r_vld_p1;
    logic [2:0]        r_wr_sel_p1;
    logic [DATA_W-1:0] r_wr_data_p1;
    logic              r_busy_p1;

    // ---- stage p0: combinational round-robin grant ----
    always_comb begin
        logic       v_found;
        logic [1:0] v_idx;
        w_gnt_p0     = '0;
        w_gnt_idx_p0 = r_rr_ptr;
        v_found      = 1'b0;
        v_idx        = r_rr_ptr;
        // Reset is folded in so gnt is quiet while rst_n is low.
        if (rst_n && !bus.hold) begin
            for (int k = 0; k < 4; k++) begin
                v_idx = r_rr_ptr + 2'(k);
                if (!v_found && bus.req[v_idx]) begin
                    v_found      = 1'b1;
                    w_gnt_idx_p0 = v_idx;
                end
            end
            if (v_found) begin
                w_gnt_p0[w_gnt_idx_p0] = 1'b1;
            end
        end
    end

    assign w_xfer_p0 = |w_gnt_p0;
    assign w_sel_p0  = bus.req_addr[3*int'(w_gnt_idx_p0) +: 3];
    assign w_data_p0 = bus.req_data[DATA_W*int'(w_gnt_idx_p0) +: DATA_W];

`ifdef RF_WR_ZERO_DISCARD_EN
    // Register 0 is constant zero: consume the request but drop the write.
    assign w_wr_vld_p0 = w_xfer_p0 && (w_sel_p0 != 3'd0);
`else
    assign w_wr_vld_p0 = w_xfer_p0;
`endif

    // ---- stage p1: registered write port and pointer ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= 2'd0;
            r_vld_p1     <= 1'b0;
            r_wr_sel_p1  <= 3'd0;
            r_wr_data_p1 <= '0;
            r_busy_p1    <= 1'b0;
        end else begin
            r_vld_p1  <= w_wr_vld_p0;
            r_busy_p1 <= (|bus.req) && !w_xfer_p0;
            if (w_xfer_p0) begin
                r_rr_ptr <= w_gnt_idx_p0 + 2'd1;
            end
            // sel/data only move when a write is actually issued, so they
            // hold their last value across idle cycles.
            if (w_wr_vld_p0) begin
                r_wr_sel_p1  <= w_sel_p0;
                r_wr_data_p1 <= w_data_p0;
            end
        end
    end

    assign bus.gnt     = w_gnt_p0;
    assign bus.wr_en   = r_vld_p1;
    assign bus.wr_sel  = r_wr_sel_p1;
    assign bus.wr_data = r_wr_data_p1;
    assign bus.busy    = r_busy_p1;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// ============================================================================
// tb_regfile_wr_arbiter
// Scoreboard bench for regfile_wr_arbiter. Inputs change on the falling edge;
// a reference model evaluates each rising edge from the applied stimulus and
// queues the expected write-port state; a monitor compares it 1 time unit
// after the rising edge. The grant is compared shortly after every input
// change.
// ============================================================================
module tb_regfile_wr_arbiter;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.DATA_W(DATA_W)) bus ();

    regfile_wr_arbiter #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit                en;
        logic [2:0]        sel;
        logic [DATA_W-1:0] data;
        bit                busy;
    } exp_t;

    exp_t q[$];

    int vectors = 0;
    int miscompares = 0;

    // Requester intent (pend/a/d/hold_v) and the copy actually on the bus.
    bit                pend   [4];
    logic [2:0]        a      [4];
    logic [DATA_W-1:0] d      [4];
    bit                hold_v;
    bit                ap_pend[4];
    logic [2:0]        ap_a   [4];
    logic [DATA_W-1:0] ap_d   [4];
    bit                ap_hold;

    int                m_ptr  = 0;
    logic [2:0]        m_sel  = '0;
    logic [DATA_W-1:0] m_data = '0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // First requesting index scanning from the pointer, modulo 4; -1 if none.
    function automatic int pick();
        int r;
        r = -1;
        if (!ap_hold) begin
            for (int k = 3; k >= 0; k--) begin
                if (ap_pend[(m_ptr + k) % 4]) r = (m_ptr + k) % 4;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] model_gnt();
        logic [3:0] g;
        int         p;
        g = 4'b0000;
        p = pick();
        if (p >= 0) g[p] = 1'b1;
        return g;
    endfunction

    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            ap_pend[i] = pend[i];
            ap_a[i]    = a[i];
            ap_d[i]    = d[i];
            bus.req[i]                     = pend[i];
            bus.req_addr[3*i +: 3]         = a[i];
            bus.req_data[DATA_W*i +: DATA_W] = d[i];
        end
        ap_hold  = hold_v;
        bus.hold = hold_v;
    endtask

    task automatic arm(input int i, input logic [2:0] ad, input logic [DATA_W-1:0] dt);
        if (!pend[i]) begin
            pend[i] = 1'b1;
            a[i]    = ad;
            d[i]    = dt;
        end
    endtask

    // One cycle: new inputs at the falling edge, then grant check.
    task automatic step(input bit rnd);
        @(negedge clk);
        if (rnd) begin
            hold_v = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 4; i++) begin
                if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
                else if (!pend[i] && $urandom_range(0, 1) == 1)
                    arm(i, 3'($urandom_range(0, 7)), DATA_W'($urandom));
            end
        end
        apply();
        #1;
        check("gnt", 32'(bus.gnt), 32'(model_gnt()));
    endtask

    // Reference model: evaluate each transfer edge from the applied inputs.
    always @(posedge clk) begin
        int   g;
        exp_t e;
        if (rst_n) begin
            g = pick();
            e.busy = (ap_pend[0] | ap_pend[1] | ap_pend[2] | ap_pend[3]) && (g < 0);
            e.en   = 1'b0;
            if (g >= 0) begin
                m_ptr   = (g + 1) % 4;
                pend[g] = 1'b0;
`ifdef RF_WR_ZERO_DISCARD_EN
                if (ap_a[g] != 3'd0) begin
`else
                begin
`endif
                    e.en   = 1'b1;
                    m_sel  = ap_a[g];
                    m_data = ap_d[g];
                end
            end
            e.sel  = m_sel;
            e.data = m_data;
            q.push_back(e);
        end
    end

    // Monitor: compare the registered write port against the queue.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            check("wr_en",   32'(bus.wr_en),   32'(e.en));
            check("wr_sel",  32'(bus.wr_sel),  32'(e.sel));
            check("wr_data", 32'(bus.wr_data), 32'(e.data));
            check("busy",    32'(bus.busy),    32'(e.busy));
        end
    end

    task automatic model_reset();
        q.delete();
        m_ptr  = 0;
        m_sel  = '0;
        m_data = '0;
        hold_v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1'b0;
            a[i]    = '0;
            d[i]    = '0;
        end
        apply();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},   32'(bus.wr_en),   32'd0);
        check({tag, "_wr_sel"},  32'(bus.wr_sel),  32'd0);
        check({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
        check({tag, "_busy"},    32'(bus.busy),    32'd0);
        check({tag, "_gnt"},     32'(bus.gnt),     32'd0);
    endtask

    initial begin
        model_reset();
        // Requests present during reset must not produce grants.
        pend[0] = 1'b1; pend[1] = 1'b1;
        apply();
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Single request: requester 2, register 5.
        arm(2, 3'd5, 16'h1234);
        step(0);
        check("gnt_single", 32'(bus.gnt), 32'h4);
        step(0);

        // Wrap from pointer 3 with requesters 0 and 3.
        arm(0, 3'd1, 16'hAAAA);
        arm(3, 3'd6, 16'h5555);
        step(0);
        check("gnt_wrap_a", 32'(bus.gnt), 32'h8);
        step(0);
        check("gnt_wrap_b", 32'(bus.gnt), 32'h1);
        step(0);

        // All four requesting continuously.
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 4; i++) arm(i, 3'($urandom_range(1, 7)), DATA_W'($urandom));
            step(0);
        end

        // Stall with everyone requesting, then release.
        for (int i = 0; i < 4; i++) arm(i, 3'(i + 2), DATA_W'(16'h0100 * (i + 1)));
        hold_v = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(0);
            check("gnt_hold", 32'(bus.gnt), 32'h0);
        end
        hold_v = 1'b0;
        for (int c = 0; c < 5; c++) step(0);

        // Write to register 0.
        arm(1, 3'd0, 16'hFFFF);
        step(0);
        step(0);
        step(0);

        // Reset in the middle of a registered write.
        arm(1, 3'd7, 16'hBEEF);
        step(0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(0);
        step(0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) step(1);

        hold_v = 1'b0;
        for (int i = 0; i < 4; i++) pend[i] = 1'b0;
        step(0);
        step(0);
        @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter: DATA_W, default 16, register data width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  per-requester write request; bit i belongs to requester i.
REQ-005 Port: req_addr  input  12  destination register; bits [3i+2:3i] belong to requester i.
REQ-006 Port: req_data  input  4*DATA_W  write data; bits [DATA_W*(i+1)-1:DATA_W*i] belong to requester i.
REQ-007 Port: hold  input  1  register-file stall; suppresses all grants while high.
REQ-008 Port: gnt  output  4  one-hot grant, combinational from req, hold and rr_ptr.
REQ-009 Port: wr_en  output  1  registered write strobe to the register file.
REQ-010 Port: wr_sel  output  3  registered destination index; drives the 3-to-8 write decoder.
REQ-011 Port: wr_data  output  DATA_W  registered write data.
REQ-012 Port: busy  output  1  registered; high when any req was high and not granted last cycle.

Function
REQ-013 Transfer for requester i occurs on a rising edge where req[i]=1 and gnt[i]=1; requester holds req, addr and data stable until then.
REQ-014 gnt shall be all-zero when hold=1 or req=0000; otherwise exactly one bit set.
REQ-015 Round-robin: grant goes to the first requesting index found scanning rr_ptr, rr_ptr+1, ... modulo 4.
REQ-016 rr_ptr (2-bit internal state) shall update to (granted index + 1) mod 4 on each transfer; unchanged otherwise.
REQ-017 Latency: one cycle; after a transfer edge, wr_en=1, wr_sel=granted addr, wr_data=granted data for exactly the next cycle.
REQ-018 Cycle with no transfer: wr_en=0 next cycle; wr_sel and wr_data hold previous values.
REQ-019 Back-to-back transfers allowed every cycle; max one write per cycle.
REQ-020 Wrap-around: rr_ptr=3 grant to requester 3 sets rr_ptr to 0.
REQ-021 Simultaneous request by all four: each served once in four consecutive cycles, order starting at rr_ptr.
REQ-022 hold rising mid-stream: no grant that cycle; rr_ptr frozen; pending write already registered still issues.
REQ-023 Request dropped before grant is legal; no write issued for it.
REQ-024 busy next cycle = (req!=0) and no transfer this cycle.

Reset
REQ-025 rst_n low shall immediately force wr_en=0, wr_sel=000, wr_data=0, busy=0, rr_ptr=00, independent of clk.
REQ-026 Reset asserted mid-operation discards any registered write; no wr_en pulse after release until a new transfer.
REQ-027 gnt is combinational and shall be all-zero while rst_n is low.

Configuration
REQ-028 Macro RF_WR_ZERO_DISCARD_EN.
REQ-029 Defined: transfer with addr 000 is granted and advances rr_ptr, but wr_en stays 0 next cycle (register 0 hard-wired zero).
REQ-030 Undefined: addr 000 treated as any other register; wr_en=1 per REQ-017.

Verification
REQ-031 Reset: rst_n=0 mid-write -> wr_en=0, wr_sel=000, wr_data=0 immediately, no clock needed.
REQ-032 Single request: req=0100, addr2=5, data2=0x1234 -> gnt=0100; next cycle wr_en=1, wr_sel=5, wr_data=0x1234; rr_ptr=3.
REQ-033 All request continuously from rr_ptr=0 -> grants 0,1,2,3,0 on successive cycles; wr_en high every cycle.
REQ-034 hold=1 with req=1111 for 3 cycles -> gnt=0000, wr_en=0, busy=1; hold=0 -> grant resumes at saved rr_ptr.
REQ-035 Wrap: rr_ptr=3, req=1001 -> gnt=1000, then gnt=0001; rr_ptr returns to 1.
REQ-036 Zero-register write addr=0, data=0xFFFF -> wr_en=0 with RF_WR_ZERO_DISCARD_EN, wr_en=1 and wr_sel=0 without.
